// File: rtl/gf180mcu_fd_sc_mcu7t5v0__deglitch.sv
// gf180mcu_fd_sc_mcu7t5v0__deglitch
// Synchronizing deglitch filter for a noisy/asynchronous inverter output.
// The input is brought into the CLK domain through a flop chain. A level is
// then accepted only after it has disagreed with the current output for
// FILT_CYCLES consecutive enabled cycles. Accepted transitions produce
// one-cycle rise/fall strobes and advance a saturating edge counter.
//
// State (single filter datapath, no enumerated FSM):
//   sync_q | synchronizer chain, sync_q[0] samples I
//   stab_q | consecutive enabled cycles on which SI != Q
//   q_q    | filtered level
//
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset, highest priority
//   I    - asynchronous input
//   EN   - filter enable (synchronizer runs regardless)
//   CLR  - synchronous clear of CNT and SAT
//   Q    - filtered level
//   QR   - one-cycle strobe on Q 0->1
//   QF   - one-cycle strobe on Q 1->0
//   CNT  - saturating count of Q transitions
//   SAT  - sticky: transition seen while CNT was all-ones
//   VDD, VSS - power pins, only with USE_POWER_PINS, no function
module gf180mcu_fd_sc_mcu7t5v0__deglitch #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RST,
    input  logic             I,
    input  logic             EN,
    input  logic             CLR,
    output logic             Q,
    output logic             QR,
    output logic             QF,
    output logic [CNT_W-1:0] CNT,
    output logic             SAT
);

    localparam int STAB_W = $clog2(FILT_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [STAB_W-1:0]      stab_q, stab_d;
    logic                   q_q, q_d;
    logic                   qr_q, qr_d;
    logic                   qf_q, qf_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic                   si;
    logic                   flip;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], I};
        si     = sync_q[SYNC_STAGES-1];

        q_d    = q_q;
        stab_d = '0;
        qr_d   = 1'b0;
        qf_d   = 1'b0;
        flip   = 1'b0;

        // Any agreeing cycle or a disabled cycle restarts the stability count,
        // so only an uninterrupted run of disagreement reaches the threshold.
        if (EN && (si != q_q)) begin
            if (stab_q == STAB_LAST) begin
                q_d  = si;
                qr_d = si;
                qf_d = ~si;
                flip = 1'b1;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end

        cnt_d = cnt_q;
        sat_d = sat_q;
        // Clear wins over a same-edge increment or saturation.
        if (CLR) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (flip) begin
            if (&cnt_q) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            stab_q <= '0;
            q_q    <= 1'b0;
            qr_q   <= 1'b0;
            qf_q   <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            stab_q <= stab_d;
            q_q    <= q_d;
            qr_q   <= qr_d;
            qf_q   <= qf_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign Q   = q_q;
    assign QR  = qr_q;
    assign QF  = qf_q;
    assign CNT = cnt_q;
    assign SAT = sat_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__deglitch.sv
// Bench for the deglitch filter: two instances (default parameters, and a
// short-filter / narrow-counter variant) share the same stimulus and are
// compared every cycle against a behavioural model, plus directed checks
// of latency, glitch rejection and pulse acceptance.
module tb_gf180mcu_fd_sc_mcu7t5v0__deglitch;

    localparam int SS0 = 2, FC0 = 4, CW0 = 8;
    localparam int SS1 = 3, FC1 = 1, CW1 = 2;

    logic CLK = 1'b0;
    logic RST, I, EN, CLR;

    logic q0, qr0, qf0, sat0;
    logic [CW0-1:0] cnt0;
    logic q1, qr1, qf1, sat1;
    logic [CW1-1:0] cnt1;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__deglitch #(.SYNC_STAGES(SS0), .FILT_CYCLES(FC0), .CNT_W(CW0)) dut0 (
        .CLK(CLK), .RST(RST), .I(I), .EN(EN), .CLR(CLR),
        .Q(q0), .QR(qr0), .QF(qf0), .CNT(cnt0), .SAT(sat0)
    );

    gf180mcu_fd_sc_mcu7t5v0__deglitch #(.SYNC_STAGES(SS1), .FILT_CYCLES(FC1), .CNT_W(CW1)) dut1 (
        .CLK(CLK), .RST(RST), .I(I), .EN(EN), .CLR(CLR),
        .Q(q1), .QR(qr1), .QF(qf1), .CNT(cnt1), .SAT(sat1)
    );

    // Behavioural model: SI is I delayed by the synchronizer depth; Q flips
    // once SI has differed from it for FC consecutive enabled cycles.
    bit m_dly[2][8];
    int m_run[2];
    bit m_q[2], m_qr[2], m_qf[2], m_sat[2];
    int m_cnt[2];

    task automatic model_step(input int k, input int ss, input int fc, input int cw);
        bit si;
        bit moved;
        if (RST) begin
            for (int j = 0; j < 8; j++) m_dly[k][j] = 1'b0;
            m_run[k] = 0; m_q[k] = 0; m_qr[k] = 0; m_qf[k] = 0;
            m_cnt[k] = 0; m_sat[k] = 0;
        end else begin
            si = m_dly[k][ss-1];
            for (int j = 7; j > 0; j--) m_dly[k][j] = m_dly[k][j-1];
            m_dly[k][0] = I;
            moved = 1'b0;
            if (EN && si != m_q[k]) m_run[k] = m_run[k] + 1;
            else m_run[k] = 0;
            if (m_run[k] >= fc) begin
                m_q[k] = si;
                m_run[k] = 0;
                moved = 1'b1;
            end
            m_qr[k] = moved && si;
            m_qf[k] = moved && !si;
            if (CLR) begin
                m_cnt[k] = 0;
                m_sat[k] = 0;
            end else if (moved) begin
                if (m_cnt[k] == (1 << cw) - 1) m_sat[k] = 1;
                else m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    always @(posedge CLK) begin
        model_step(0, SS0, FC0, CW0);
        model_step(1, SS1, FC1, CW1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and compare both instances at the falling edge.
    task automatic cycle();
        @(negedge CLK);
        chk("d0_q",   int'(q0),   int'(m_q[0]));
        chk("d0_qr",  int'(qr0),  int'(m_qr[0]));
        chk("d0_qf",  int'(qf0),  int'(m_qf[0]));
        chk("d0_cnt", int'(cnt0), m_cnt[0]);
        chk("d0_sat", int'(sat0), int'(m_sat[0]));
        chk("d1_q",   int'(q1),   int'(m_q[1]));
        chk("d1_qr",  int'(qr1),  int'(m_qr[1]));
        chk("d1_qf",  int'(qf1),  int'(m_qf[1]));
        chk("d1_cnt", int'(cnt1), m_cnt[1]);
        chk("d1_sat", int'(sat1), int'(m_sat[1]));
    endtask

    task automatic do_reset();
        RST = 1'b1; I = 1'b0; EN = 1'b1; CLR = 1'b0;
        repeat (3) cycle();
        chk("rst_q",   int'(q0),   0);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_sat", int'(sat1), 0);
        RST = 1'b0;
        repeat (3) cycle();
    endtask

    int seen0, seen1;
    int hold, en_hold;
    bit q0_high;

    initial begin
        RST = 1'b1; I = 1'b0; EN = 1'b1; CLR = 1'b0;
        @(negedge CLK);
        do_reset();

        // Glitches of 1..3 periods must be rejected by the default instance.
        for (int w = 1; w <= 3; w++) begin
            I = 1'b1;
            repeat (w) cycle();
            I = 1'b0;
            q0_high = 1'b0;
            for (int n = 0; n < 10; n++) begin
                cycle();
                if (q0 || qr0 || qf0) q0_high = 1'b1;
            end
            chk("glitch_quiet", int'(q0_high), 0);
            chk("glitch_cnt", int'(cnt0), 0);
        end
        // A 4-period pulse is accepted: rise then fall, two transitions.
        I = 1'b1;
        repeat (4) cycle();
        I = 1'b0;
        repeat (12) cycle();
        chk("pulse4_cnt", int'(cnt0), 2);
        chk("pulse4_q", int'(q0), 0);

        // Input-to-output latency, counting the first edge after I changes as 1.
        do_reset();
        I = 1'b1;
        seen0 = 0; seen1 = 0;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            if (qr0 && seen0 == 0) seen0 = n;
            if (qr1 && seen1 == 0) seen1 = n;
        end
        chk("lat_d0", seen0, SS0 + FC0);
        chk("lat_d1", seen1, SS1 + FC1);
        chk("lat_cnt", int'(cnt0), 1);

        // Randomized traffic; the model covers EN windows, CLR and RST.
        hold = 0; en_hold = 0;
        for (int n = 0; n < 4000; n++) begin
            cycle();
            if (hold == 0) begin
                I = ~I;
                hold = $urandom_range(1, 10);
            end
            hold--;
            if (en_hold == 0) begin
                EN = ($urandom_range(0, 5) != 0);
                en_hold = $urandom_range(5, 30);
            end
            en_hold--;
            CLR = ($urandom_range(0, 49) == 0);
            RST = ($urandom_range(0, 149) == 0);
        end
        RST = 1'b0; CLR = 1'b0;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
